lv_pwm_intb_decode: RTL and testbench
=====================================

// Module: lv_pwm_intb_decode
// PURPOSE
//  LV-side receiver for the PWM feedback channel that the HV die reuses to send INTB.
//  Compares the received line i_pwm_intb_rx with the locally known gate wave i_pwm_ref.
//  Decodes two frame types: 1-bit INTB0 (interrupt asserted) and 3-bit INTB1 (released).
//  Rebuilds o_lv_intb_n, flags malformed frames and raises a watchdog error when HV refreshes stop.
// PARAMETERS
//  EXT_CYC_NUM  8      cycles per encoded bit; must match the HV encoder extend length
//  TOL          1      +/- cycle tolerance on every bit/gap length; require TOL < EXT_CYC_NUM/2
//  WDG_CNT_W    16     watchdog counter width
//  WDG_TO_TH0   1024   timeout in cycles for i_wdgintb_config=0 (TH1..TH3: 2048,4096,8192)
// PORTS
//  i_clk             in   1          system clock
//  i_rst             in   1          asynchronous, active-high reset
//  i_pwm_intb_rx     in   1          received PWM/INTB line, already synchronized to i_clk
//  i_pwm_ref         in   1          local gate wave, latency-aligned to i_pwm_intb_rx
//  i_wdgintb_en      in   1          watchdog enable
//  i_wdgintb_config  in   2          selects WDG_TO_TH0..3
//  o_lv_intb_n       out  1          decoded HV INTB level; 0 = interrupt
//  o_frm_vld         out  1          1-cycle pulse per valid decoded frame
//  o_frm_err         out  1          1-cycle pulse per malformed frame
//  o_wdg_err         out  1          level; no valid frame within the timeout
// BEHAVIOUR
//  Reset values: o_lv_intb_n=1, o_frm_vld=0, o_frm_err=0, o_wdg_err=0, FSM=IDLE, all counters 0.
//  All outputs are registered.
//  mis = i_pwm_intb_rx ^ i_pwm_ref.
//  lock = i_pwm_ref captured on the IDLE->BIT0 transition.
//  cnt = saturating per-state run counter, cleared on every state change.
//  Bit windows: LO = EXT_CYC_NUM-TOL, HI = EXT_CYC_NUM+TOL.
//  FSM states:
//   IDLE: mis=1 -> BIT0 (capture lock, cnt=1).
//   BIT0: counts while rx==~lock.
//    - rx returns to lock with cnt<LO -> IDLE silently (PWM edge skew / glitch).
//    - rx returns to lock with LO<=cnt<=HI -> GAP.
//    - cnt>HI -> ERR.
//   GAP: counts while rx==lock.
//    - rx==~lock with LO<=cnt<=HI -> BIT2.
//    - rx==~lock with cnt<LO -> ERR.
//    - cnt>HI -> INTB0 decoded, -> IDLE.
//   BIT2: counts while rx==~lock.
//    - cnt reaches LO -> INTB1 decoded, -> DRAIN.
//    - rx returns to lock with cnt<LO -> ERR.
//   DRAIN: wait for mis=0 -> IDLE; cnt>HI -> ERR.
//   ERR: pulse o_frm_err on entry; wait for mis=0 held for EXT_CYC_NUM cycles -> IDLE.
//  Decode timing, registered 1 cycle after the deciding edge:
//   INTB0: o_lv_intb_n<=0, o_frm_vld pulse.
//   INTB1: o_lv_intb_n<=1, o_frm_vld pulse.
//  o_lv_intb_n is unchanged on ERR and on silently discarded glitches.
//  Watchdog:
//   - Counter clears on o_frm_vld or i_wdgintb_en=0; otherwise increments, saturating.
//   - Counter == selected TH -> o_wdg_err<=1.
//   - o_wdg_err clears on the next o_frm_vld or when i_wdgintb_en=0.
//   - Config change mid-count: the new TH applies immediately; if count>=new TH, flag next cycle.
//  i_rst asserted mid-frame: everything returns to reset values at once; no pulse is emitted.
//  A frame starting in the same cycle that DRAIN->IDLE is taken is caught on the next mis cycle.
// TESTING
//  (EXT_CYC_NUM=8, TOL=1, ref held 0 unless noted)
//  1. rx=1 for 8 cyc then 0 -> after 10 gap cyc: o_lv_intb_n 1->0, one o_frm_vld pulse.
//  2. rx=1x8, 0x8, 1x8 -> o_lv_intb_n=1, o_frm_vld pulse 7 cyc after 3rd bit starts, no o_frm_err.
//  3. rx=1 for 3 cyc (edge skew) -> no pulses, o_lv_intb_n unchanged; rx=1 for 12 cyc -> o_frm_err.
//  4. rx=1x8, 0x4, 1x8 -> o_frm_err pulse, o_lv_intb_n unchanged.
//  5. wdg_en=1, config=0, no frames -> o_wdg_err=1 at cycle 1024; a valid frame clears it.
//  6. Assert i_rst during GAP of an INTB1 frame -> outputs at reset values; next clean INTB0 decodes.

Source files
------------

// File: rtl/lv_pwm_intb_decode.sv
// LV-side INTB decoder: compares the returned PWM line against the local gate wave, decodes INTB0/INTB1 frames, flags bad frames and stale-link timeouts.
// Outputs registered, decode visible 1 cycle after the deciding edge; no backpressure, the line is sampled every cycle.
module lv_pwm_intb_decode #(
    parameter int EXT_CYC_NUM = 8,
    parameter int TOL         = 1,
    parameter int WDG_CNT_W   = 16,
    parameter int WDG_TO_TH0  = 1024,
    parameter int WDG_TO_TH1  = 2048,
    parameter int WDG_TO_TH2  = 4096,
    parameter int WDG_TO_TH3  = 8192
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pwm_intb_rx,
    input  logic       i_pwm_ref,
    input  logic       i_wdgintb_en,
    input  logic [1:0] i_wdgintb_config,
    output logic       o_lv_intb_n,
    output logic       o_frm_vld,
    output logic       o_frm_err,
    output logic       o_wdg_err
);

    localparam int LO    = EXT_CYC_NUM - TOL;
    localparam int HI    = EXT_CYC_NUM + TOL;
    localparam int CNT_W = $clog2(HI + 2) + 1;

    localparam logic [CNT_W-1:0] LO_C  = CNT_W'(LO);
    localparam logic [CNT_W-1:0] HI_C  = CNT_W'(HI);
    localparam logic [CNT_W-1:0] EXT_C = CNT_W'(EXT_CYC_NUM);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIT0,
        ST_GAP,
        ST_BIT2,
        ST_DRAIN,
        ST_ERR
    } st_t;

    st_t              st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             lock_q, lock_d;
    logic             dec0, dec1, err_ent;
    logic             mis, mark;

    logic [WDG_CNT_W-1:0] wdg_cnt_q, wdg_th;

    assign mis     = i_pwm_intb_rx ^ i_pwm_ref;
    // mark = line sits at the inverse of the level latched at frame start
    assign mark    = i_pwm_intb_rx ^ lock_q;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ONE_C;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        lock_d  = lock_q;
        dec0    = 1'b0;
        dec1    = 1'b0;
        err_ent = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (mis) begin
                    st_d   = ST_BIT0;
                    lock_d = i_pwm_ref;
                    cnt_d  = ONE_C;
                end
            end
            ST_BIT0: begin
                if (mark) begin
                    if (cnt_q >= HI_C) begin
                        st_d    = ST_ERR;
                        cnt_d   = '0;
                        err_ent = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (cnt_q < LO_C) begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                end else begin
                    st_d  = ST_GAP;
                    cnt_d = ONE_C;
                end
            end
            ST_GAP: begin
                if (!mark) begin
                    if (cnt_q >= HI_C) begin
                        st_d  = ST_IDLE;
                        cnt_d = '0;
                        dec0  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (cnt_q < LO_C) begin
                    st_d    = ST_ERR;
                    cnt_d   = '0;
                    err_ent = 1'b1;
                end else begin
                    st_d  = ST_BIT2;
                    cnt_d = ONE_C;
                end
            end
            ST_BIT2: begin
                if (mark) begin
                    if (cnt_inc >= LO_C) begin
                        st_d  = ST_DRAIN;
                        cnt_d = '0;
                        dec1  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    st_d    = ST_ERR;
                    cnt_d   = '0;
                    err_ent = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!mis) begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                end else if (cnt_q >= HI_C) begin
                    st_d    = ST_ERR;
                    cnt_d   = '0;
                    err_ent = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ERR: begin
                // recover only after a full bit time of quiet line
                if (mis) begin
                    cnt_d = '0;
                end else if (cnt_inc >= EXT_C) begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                st_d  = ST_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_lv_intb_n <= 1'b1;
            o_frm_vld   <= 1'b0;
            o_frm_err   <= 1'b0;
        end else begin
            o_frm_vld <= dec0 | dec1;
            o_frm_err <= err_ent;
            if (dec0) begin
                o_lv_intb_n <= 1'b0;
            end else if (dec1) begin
                o_lv_intb_n <= 1'b1;
            end
        end
    end

    always_comb begin
        wdg_th = WDG_CNT_W'(WDG_TO_TH0);
        case (i_wdgintb_config)
            2'd0:    wdg_th = WDG_CNT_W'(WDG_TO_TH0);
            2'd1:    wdg_th = WDG_CNT_W'(WDG_TO_TH1);
            2'd2:    wdg_th = WDG_CNT_W'(WDG_TO_TH2);
            default: wdg_th = WDG_CNT_W'(WDG_TO_TH3);
        endcase
    end

    // >= rather than == so a threshold lowered mid-count still fires
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wdg_cnt_q <= '0;
            o_wdg_err <= 1'b0;
        end else if (!i_wdgintb_en || o_frm_vld) begin
            wdg_cnt_q <= '0;
            o_wdg_err <= 1'b0;
        end else begin
            if (wdg_cnt_q != '1) begin
                wdg_cnt_q <= wdg_cnt_q + WDG_CNT_W'(1);
            end
            if (wdg_cnt_q >= wdg_th) begin
                o_wdg_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lv_pwm_intb_decode.sv
// Bench for lv_pwm_intb_decode: directed frame timing, watchdog and reset cases, then random frames against a run-length frame model.
module tb_lv_pwm_intb_decode;

    localparam int EXT = 8;
    localparam int TOL = 1;
    localparam int LO  = EXT - TOL;
    localparam int HI  = EXT + TOL;

    localparam int R_NONE  = 0;
    localparam int R_INTB0 = 1;
    localparam int R_INTB1 = 2;
    localparam int R_ERR   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b0;
    logic       ref_w = 1'b0;
    logic       wen = 1'b0;
    logic [1:0] wcfg = 2'd0;
    logic       intb_n, frm_vld, frm_err, wdg_err;

    int n_tests = 0;
    int n_fail  = 0;
    int vld_seen = 0;
    int err_seen = 0;
    int v0, e0;
    logic exp_intb;

    always #5 clk = ~clk;

    lv_pwm_intb_decode #(
        .EXT_CYC_NUM(EXT),
        .TOL(TOL)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_pwm_intb_rx(rx),
        .i_pwm_ref(ref_w),
        .i_wdgintb_en(wen),
        .i_wdgintb_config(wcfg),
        .o_lv_intb_n(intb_n),
        .o_frm_vld(frm_vld),
        .o_frm_err(frm_err),
        .o_wdg_err(wdg_err)
    );

    always @(posedge clk) begin
        #1;
        if (frm_vld) vld_seen++;
        if (frm_err) err_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mark=1 drives the line opposite to the reference for n cycles
    task automatic drive(input logic mark, input int n);
        for (int i = 0; i < n; i++) begin
            rx = mark ^ ref_w;
            @(negedge clk);
        end
    endtask

    // Frame outcome from run lengths: m1 first mark, g gap (0 = line stays idle), m2 third mark
    function automatic int frame_result(input int m1, input int g, input int m2);
        if (m1 < LO) return R_NONE;
        if (m1 > HI) return R_ERR;
        if (g == 0)  return R_INTB0;
        if (g < LO)  return R_ERR;
        if (m2 < LO) return R_ERR;
        return R_INTB1;
    endfunction

    initial begin
        @(negedge clk);
        repeat (2) @(negedge clk);
        chk("rst_intb_n", intb_n, 1);
        chk("rst_frm_vld", frm_vld, 0);
        chk("rst_frm_err", frm_err, 0);
        chk("rst_wdg_err", wdg_err, 0);
        rst = 1'b0;
        drive(0, 4);

        // INTB0: decode after the 10th gap cycle
        v0 = vld_seen;
        drive(1, 8);
        drive(0, 9);
        chk("t1_pre_vld", frm_vld, 0);
        chk("t1_pre_intb", intb_n, 1);
        drive(0, 1);
        chk("t1_vld", frm_vld, 1);
        chk("t1_intb", intb_n, 0);
        drive(0, 10);
        chk("t1_vld_cnt", vld_seen - v0, 1);

        // edge-skew glitch is dropped silently, an over-long bit is an error
        v0 = vld_seen; e0 = err_seen;
        drive(1, 3);
        drive(0, 12);
        chk("t3_glitch_vld", vld_seen - v0, 0);
        chk("t3_glitch_err", err_seen - e0, 0);
        chk("t3_glitch_intb", intb_n, 0);
        drive(1, 12);
        drive(0, 12);
        chk("t3_long_err", err_seen - e0, 1);
        chk("t3_long_vld", vld_seen - v0, 0);
        chk("t3_long_intb", intb_n, 0);

        // INTB1: pulse 7 cycles into the third bit
        v0 = vld_seen; e0 = err_seen;
        drive(1, 8);
        drive(0, 8);
        drive(1, 6);
        chk("t2_pre_vld", frm_vld, 0);
        drive(1, 1);
        chk("t2_vld", frm_vld, 1);
        chk("t2_intb", intb_n, 1);
        drive(1, 1);
        drive(0, 12);
        chk("t2_vld_cnt", vld_seen - v0, 1);
        chk("t2_err_cnt", err_seen - e0, 0);

        // short gap
        v0 = vld_seen; e0 = err_seen;
        drive(1, 8);
        drive(0, 4);
        drive(1, 8);
        drive(0, 12);
        chk("t4_err_cnt", err_seen - e0, 1);
        chk("t4_vld_cnt", vld_seen - v0, 0);
        chk("t4_intb", intb_n, 1);

        // reset in the gap of an INTB1 frame
        drive(1, 8);
        drive(0, 20);
        chk("t6_pre_intb", intb_n, 0);
        v0 = vld_seen; e0 = err_seen;
        drive(1, 8);
        drive(0, 3);
        rst = 1'b1;
        #1;
        chk("t6_rst_intb", intb_n, 1);
        chk("t6_rst_vld", frm_vld, 0);
        chk("t6_rst_err", frm_err, 0);
        rx = ref_w;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(0, 4);
        drive(1, 8);
        drive(0, 20);
        chk("t6_post_vld_cnt", vld_seen - v0, 1);
        chk("t6_post_err_cnt", err_seen - e0, 0);
        chk("t6_post_intb", intb_n, 0);

        // watchdog
        wen = 1'b1; wcfg = 2'd0;
        drive(0, 1020);
        chk("t5_wdg_early", wdg_err, 0);
        drive(0, 10);
        chk("t5_wdg_timeout", wdg_err, 1);
        drive(1, 8);
        drive(0, 10);
        chk("t5_frame_vld", frm_vld, 1);
        drive(0, 1);
        chk("t5_wdg_cleared", wdg_err, 0);
        wcfg = 2'd3;
        drive(0, 2000);
        chk("t5_wdg_th3_quiet", wdg_err, 0);
        wcfg = 2'd0;
        drive(0, 2);
        chk("t5_wdg_cfg_drop", wdg_err, 1);
        wen = 1'b0;
        drive(0, 1);
        chk("t5_wdg_disable", wdg_err, 0);

        // random frames; the last directed frame was INTB0
        exp_intb = 1'b0;
        for (int k = 0; k < 40; k++) begin
            int kind, m1, g, m2, res;
            ref_w = 1'($urandom_range(0, 1));
            rx = ref_w;
            kind = $urandom_range(0, 5);
            g = 0; m2 = 0;
            case (kind)
                0: m1 = $urandom_range(1, LO - 1);
                1: m1 = $urandom_range(HI + 1, HI + 6);
                2: m1 = $urandom_range(LO, HI);
                3: begin
                    m1 = $urandom_range(LO, HI);
                    g  = $urandom_range(1, LO - 1);
                    m2 = $urandom_range(1, 10);
                end
                4: begin
                    m1 = $urandom_range(LO, HI);
                    g  = $urandom_range(LO, HI);
                    m2 = $urandom_range(LO, HI);
                end
                default: begin
                    m1 = $urandom_range(LO, HI);
                    g  = $urandom_range(LO, HI);
                    m2 = $urandom_range(1, LO - 1);
                end
            endcase
            v0 = vld_seen; e0 = err_seen;
            drive(1, m1);
            if (g > 0) begin
                drive(0, g);
                drive(1, m2);
            end
            drive(0, 24);
            res = frame_result(m1, g, m2);
            if (res == R_INTB0) exp_intb = 1'b0;
            if (res == R_INTB1) exp_intb = 1'b1;
            chk("rnd_vld_cnt", vld_seen - v0, (res == R_INTB0 || res == R_INTB1) ? 1 : 0);
            chk("rnd_err_cnt", err_seen - e0, (res == R_ERR) ? 1 : 0);
            chk("rnd_intb", intb_n, exp_intb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
